rr_mux_arbiter4: RTL and testbench
==================================

Name: rr_mux_arbiter4

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit output channel among four requesters.
- Grants one requester at a time, drives the 2-bit mux select and steers that requester's data to the output.
- Each grant holds for a bounded burst of beats, with a valid/ready handshake toward the consumer.
- Sits in front of the shared 4:1 select datapath and owns its select lines.

Parameters:
- WIDTH, 8, data width per requester and of out_data.
- MAX_HOLD, 4, maximum beats transferred per grant; legal range 1..15.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  per-requester request; req[i] high means requester i has a beat available.
- in_data  input  4*WIDTH  requester i data on in_data[i*WIDTH +: WIDTH].
- out_ready  input  1  consumer accepts a beat this cycle.
- grant  output  4  registered one-hot grant; all zero when idle.
- sel  output  2  registered select index of the current or last grant.
- out_valid  output  1  beat presented on out_data.
- out_data  output  WIDTH  in_data slice selected by sel.
- ack  output  4  one-hot pulse; ack[i] high in the cycle a beat from requester i transfers.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset values:
  - state = IDLE, ptr = 0, cnt = 0.
  - grant = 0000, sel = 00, out_valid = 0, ack = 0000.
  - out_data = in_data slice 0 (follows sel).
- State IDLE:
  - out_valid = 0, ack = 0.
  - If req != 0, pick the first i with req[i]=1, scanning circularly ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next edge: state = BUSY, grant = onehot(i), sel = i, cnt = 0.
  - Request-to-grant latency is 1 cycle.
  - If req == 0, stay in IDLE; sel holds its last value.
- State BUSY:
  - out_valid = req[sel] (combinational).
  - out_data = in_data[sel*WIDTH +: WIDTH] (combinational).
  - xfer = out_valid & out_ready.
  - ack = grant when xfer = 1, else 0000 (combinational).
  - On xfer with cnt < MAX_HOLD-1: cnt increments and state stays BUSY.
- Release conditions, evaluated in BUSY:
  - (a) xfer = 1 and cnt == MAX_HOLD-1; this final beat is still acked.
  - (b) req[sel] == 0, so no transfer occurs this cycle.
- On release, next edge: state = IDLE, grant = 0000, cnt = 0, ptr = sel+1 mod 4 (wraps 3 to 0). sel is held.
- One idle bubble cycle always separates consecutive grants.
- Backpressure: out_ready = 0 with req[sel] = 1 means no ack, cnt unchanged, grant held indefinitely.
- req of non-granted requesters is ignored while BUSY.
- MAX_HOLD = 1: every transferred beat releases the grant.
- cnt width is 4 bits.
- Simultaneous events:
  - A requester dropping req in the same cycle out_ready rises gets no transfer; release follows via (b).
  - Reset has priority over every other event.
- Reset mid-burst: no ack in the reset cycle. All state returns to reset values at that edge; ptr returns to 0.
- Invariants checked by the bench:
  - grant is zero or one-hot.
  - ack is a subset of grant.
  - out_valid implies grant != 0.

Test Plan:
1. Reset: hold reset 2 cycles with req=1111, out_ready=1 -> grant=0000, sel=00, out_valid=0, ack=0000 throughout; first grant=0001 one cycle after reset falls.
2. Single requester: req=0010, out_ready=1, in_data[1]=8'hA5, MAX_HOLD=4:
   - grant=0010 and sel=01 at cycle 1.
   - out_data=A5 and ack=0010 for 4 cycles.
   - Release and 1 bubble cycle (grant=0000), then grant=0010 again.
3. Full contention: req=1111, out_ready=1 -> grant sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 4 acked beats separated by one bubble; sel runs 0,1,2,3,0.
4. Backpressure: grant=0100 after 1 beat; out_ready=0 for 3 cycles, then 1:
   - No ack during the stall, grant held.
   - Exactly 3 further acks follow, then release.
5. Early drop and wrap: req=0101 with ptr=2:
   - Grant 0100; req[2] drops after 2 beats -> release with ptr=3.
   - Next grant is 0001 (wrap 3 to 0).
6. Reset mid-burst: assert reset during the 2nd beat of a grant=1000 burst with req=1111 -> no ack that cycle; after reset the first grant is 0001 (ptr reset to 0).

Source files
------------

// File: rtl/rr_mux_arbiter4_if.sv
// Shared-channel bundle between four requesters, the arbiter and the downstream consumer.
interface rr_mux_arbiter4_if #(
    parameter int unsigned WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] in_data;
    logic               out_ready;
    logic [3:0]         grant;
    logic [1:0]         sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [3:0]         ack;

    modport master (
        output req, in_data, out_ready,
        input  grant, sel, out_valid, out_data, ack
    );

    modport slave (
        input  req, in_data, out_ready,
        output grant, sel, out_valid, out_data, ack
    );
endinterface

// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter for four requesters sharing one output channel; each grant
// carries a bounded burst and is always followed by one idle bubble cycle.
module rr_mux_arbiter4 #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    rr_mux_arbiter4_if.slave  bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         grant_q, grant_d;

    logic               found_c;
    logic [1:0]         pick_c;
    logic               out_valid_c;
    logic               xfer_c;
    logic [3:0]         ack_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            grant_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    // Circular priority scan starting at ptr.
    always_comb begin
        found_c = 1'b0;
        pick_c  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!found_c && bus.req[2'(ptr_q + 2'(k))]) begin
                found_c = 1'b1;
                pick_c  = 2'(ptr_q + 2'(k));
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        // Reset suppresses the handshake so a burst cut by reset never acks.
        out_valid_c = !reset && (state_q == BUSY) && bus.req[sel_q];
        xfer_c      = out_valid_c && bus.out_ready;
        ack_c       = xfer_c ? grant_q : 4'b0000;

        unique case (state_q)
            IDLE: begin
                if (found_c) begin
                    state_d = BUSY;
                    grant_d = 4'b0001 << pick_c;
                    sel_d   = pick_c;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (!bus.req[sel_q] || (xfer_c && (cnt_q == LAST_BEAT))) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    cnt_d   = '0;
                    ptr_d   = 2'(sel_q + 2'd1);
                end else if (xfer_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid_c;
    assign bus.ack       = ack_c;
    assign bus.out_data  = bus.in_data[32'(sel_q) * WIDTH +: WIDTH];
endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Scoreboard bench for rr_mux_arbiter4: stimulus queues expected grants and beats,
// a negedge monitor pops and compares them and checks the channel invariants.
module tb_rr_mux_arbiter4;
    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [1:0]       idx;
        logic [WIDTH-1:0] data;
    } beat_t;

    logic clk;
    logic reset;

    rr_mux_arbiter4_if #(.WIDTH(WIDTH)) bus ();

    rr_mux_arbiter4 #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int beats_seen = 0;

    beat_t      exp_beats[$];
    logic [1:0] exp_grants[$];
    logic [WIDTH-1:0] dval [4];
    logic [3:0] prev_grant = 4'b0000;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_burst(input logic [1:0] idx, input int beats);
        beat_t b;
        exp_grants.push_back(idx);
        for (int i = 0; i < beats; i++) begin
            b.idx  = idx;
            b.data = dval[idx];
            exp_beats.push_back(b);
        end
    endtask

    // Returns at posedge+1 of the cycle after the target beat was observed.
    task automatic wait_beats(input int target, input int budget);
        int n = 0;
        while (beats_seen < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(beats_seen >= target, "beat_timeout", 32'(beats_seen), 32'(target));
        #1;
    endtask

    // Monitor: invariants every cycle, scoreboard pops on transfers and grant starts.
    always @(negedge clk) begin
        beat_t b;
        logic [1:0] g;
        chk($onehot0(bus.grant), "grant_onehot0", 32'(bus.grant), 32'(0));
        chk((bus.ack & ~bus.grant) == 4'b0000, "ack_subset_grant", 32'(bus.ack), 32'(bus.grant));
        chk(!bus.out_valid || (bus.grant != 4'b0000), "valid_needs_grant", 32'(bus.out_valid), 32'(bus.grant));
        if (bus.out_valid && bus.out_ready) begin
            beats_seen++;
            if (exp_beats.size() == 0) begin
                chk(1'b0, "unexpected_beat", 32'(bus.ack), 32'(0));
            end else begin
                b = exp_beats.pop_front();
                chk(bus.ack == (4'b0001 << b.idx), "beat_ack", 32'(bus.ack), 32'(4'b0001 << b.idx));
                chk(bus.out_data == b.data, "beat_data", 32'(bus.out_data), 32'(b.data));
            end
        end else begin
            chk(bus.ack == 4'b0000, "ack_without_xfer", 32'(bus.ack), 32'(0));
        end
        if (bus.grant != 4'b0000 && prev_grant == 4'b0000) begin
            if (exp_grants.size() == 0) begin
                chk(1'b0, "unexpected_grant", 32'(bus.grant), 32'(0));
            end else begin
                g = exp_grants.pop_front();
                chk(bus.grant == (4'b0001 << g), "grant_order", 32'(bus.grant), 32'(4'b0001 << g));
                chk(bus.sel == g, "grant_sel", 32'(bus.sel), 32'(g));
            end
        end
        prev_grant = bus.grant;
    end

    initial begin
        int base;
        dval[0] = 8'h10; dval[1] = 8'hA5; dval[2] = 8'h3C; dval[3] = 8'hC3;
        bus.in_data   = {dval[3], dval[2], dval[1], dval[0]};
        reset         = 1'b1;
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;

        // Reset with everyone requesting, then full contention 0,1,2,3,0.
        for (int i = 0; i < 5; i++) push_burst(2'(i % 4), 4);
        repeat (2) begin
            @(negedge clk);
            chk(bus.grant == 4'b0000, "reset_grant", 32'(bus.grant), 32'(0));
            chk(bus.sel == 2'd0, "reset_sel", 32'(bus.sel), 32'(0));
            chk(bus.out_valid == 1'b0, "reset_valid", 32'(bus.out_valid), 32'(0));
            chk(bus.out_data == dval[0], "reset_out_data", 32'(bus.out_data), 32'(dval[0]));
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk(bus.grant == 4'b0000, "grant_not_early", 32'(bus.grant), 32'(0));
        @(negedge clk);
        chk(bus.grant == 4'b0001, "first_grant", 32'(bus.grant), 32'(4'b0001));
        wait_beats(20, 60);
        bus.req = 4'b0000;

        // Single requester 1: two bursts separated by a bubble.
        push_burst(2'd1, 4);
        push_burst(2'd1, 4);
        @(posedge clk); #1;
        bus.req = 4'b0010;
        @(negedge clk);
        chk(bus.grant == 4'b0000, "single_latency", 32'(bus.grant), 32'(0));
        @(negedge clk);
        chk(bus.grant == 4'b0010, "single_grant", 32'(bus.grant), 32'(4'b0010));
        chk(bus.sel == 2'd1, "single_sel", 32'(bus.sel), 32'(1));
        wait_beats(28, 40);
        bus.req = 4'b0000;
        @(negedge clk);
        chk(bus.grant == 4'b0000, "idle_grant", 32'(bus.grant), 32'(0));
        chk(bus.sel == 2'd1, "idle_sel_held", 32'(bus.sel), 32'(1));

        // Early drop at ptr=2, then wrap from 3 to requester 0.
        push_burst(2'd2, 2);
        push_burst(2'd0, 4);
        @(posedge clk); #1;
        bus.req = 4'b0101;
        wait_beats(30, 20);
        bus.req = 4'b0001;
        wait_beats(34, 30);
        bus.req = 4'b0000;

        // Backpressure: one beat, three stalled cycles, three more beats.
        push_burst(2'd2, 4);
        base = beats_seen;
        @(posedge clk); #1;
        bus.req = 4'b0100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(bus.ack == 4'b0000, "stall_ack", 32'(bus.ack), 32'(0));
            chk(bus.grant == 4'b0100, "stall_grant", 32'(bus.grant), 32'(4'b0100));
            @(posedge clk); #1;
        end
        chk(beats_seen == base + 1, "stall_beat_count", 32'(beats_seen), 32'(base + 1));
        bus.out_ready = 1'b1;
        wait_beats(base + 4, 20);
        bus.req = 4'b0000;
        @(negedge clk);
        chk(bus.grant == 4'b0000, "stall_release", 32'(bus.grant), 32'(0));

        // Reset during the second beat of requester 3's burst.
        push_burst(2'd3, 1);
        push_burst(2'd0, 4);
        base = beats_seen;
        @(posedge clk); #1;
        bus.req = 4'b1111;
        wait_beats(base + 1, 20);
        reset = 1'b1;
        @(negedge clk);
        chk(bus.ack == 4'b0000, "reset_mid_ack", 32'(bus.ack), 32'(0));
        chk(bus.out_valid == 1'b0, "reset_mid_valid", 32'(bus.out_valid), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk(bus.grant == 4'b0000, "post_reset_idle", 32'(bus.grant), 32'(0));
        chk(bus.sel == 2'd0, "post_reset_sel", 32'(bus.sel), 32'(0));
        wait_beats(base + 5, 20);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);

        chk(exp_beats.size() == 0, "beats_left", 32'(exp_beats.size()), 32'(0));
        chk(exp_grants.size() == 0, "grants_left", 32'(exp_grants.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
